unstripe_lane_scheduler: RTL and testbench

- Controller for the two-lane byte unstripping path.
- Buffers bytes from stripe lanes 0/1 in per-lane FIFOs and interleaves them into one stream: lane 0, lane 1, lane 0, …
- Stripes arrive once per clk_f period, signalled by a strobe; the merged stream leaves at up to one byte per clk_2f cycle.
- An alignment FSM detects lane skew and recovers from it.

---
 rtl/unstripe_lane_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_unstripe_lane_scheduler.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/unstripe_lane_scheduler.sv
// unstripe_lane_scheduler
// Merges two byte stripe lanes back into one stream (lane 0, lane 1, ...).
// Each lane is buffered in a small FIFO. An alignment FSM tracks lane skew
// and flushes both FIFOs when one lane starves for too long.
// Optional build macro: UNSTRIPE_IDLE_FILL_EN. When defined, data_demux
// shows IDLE_BYTE whenever valid_demux is low, including in reset.
//
// state | meaning
// IDLE  | waiting until both lanes hold data; no output
// RUN   | popping lanes alternately; counting starved cycles
// ERR   | one cycle: flush both FIFOs, flag skew, return to IDLE
`timescale 1ns/1ps
module unstripe_lane_scheduler #(
  parameter int          DEPTH     = 4,
  parameter int          MAX_STALL = 3,
  parameter logic [7:0]  IDLE_BYTE = 8'hBC
) (
  input  logic       clk_2f,
  input  logic       reset_L,
  input  logic       stripe_stb,
  input  logic [7:0] data_stripe_0,
  input  logic       valid_stripe_0,
  input  logic [7:0] data_stripe_1,
  input  logic       valid_stripe_1,
  input  logic       err_clr,
  output logic [7:0] data_demux,
  output logic       valid_demux,
  output logic       lane_sel,
  output logic [1:0] state,
  output logic       skew_err,
  output logic       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int SW = $clog2(MAX_STALL + 1);

`ifdef UNSTRIPE_IDLE_FILL_EN
  localparam bit FILL_EN = 1'b1;
`else
  localparam bit FILL_EN = 1'b0;
`endif
  localparam logic [7:0] DATA_RST = FILL_EN ? IDLE_BYTE : 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            lane_sel_q, lane_sel_d;
  logic            valid_q, valid_d;
  logic [7:0]      data_q, data_d;
  logic [SW-1:0]   stall_q, stall_d;
  logic            skew_set;

  logic [7:0]      mem [2][DEPTH];
  logic [PW-1:0]   wr_ptr [2];
  logic [PW-1:0]   rd_ptr [2];
  logic [7:0]      din [2];
  logic [1:0]      vin, empty, full, stb_v, push, pop, drop;
  logic [7:0]      pop_data;

  assign din[0] = data_stripe_0;
  assign din[1] = data_stripe_1;
  assign vin    = {valid_stripe_1, valid_stripe_0};

  // FIFO status and push/pop/drop decisions per lane
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      empty[k] = (wr_ptr[k] == rd_ptr[k]);
      full[k]  = (wr_ptr[k][AW] != rd_ptr[k][AW]) &&
                 (wr_ptr[k][AW-1:0] == rd_ptr[k][AW-1:0]);
      pop[k]   = (state_q == ST_RUN) && (lane_sel_q == 1'(k)) && !empty[k];
      // pushes arriving during the flush cycle are thrown away, not counted as drops
      stb_v[k] = stripe_stb && vin[k] && (state_q != ST_ERR);
      push[k]  = stb_v[k] && (!full[k] || pop[k]);
      drop[k]  = stb_v[k] && full[k] && !pop[k];
    end
  end

  assign pop_data = mem[lane_sel_q][rd_ptr[lane_sel_q][AW-1:0]];

  // FIFO storage writes (no reset needed; pointers define validity)
  always_ff @(posedge clk_2f) begin
    for (int k = 0; k < 2; k++) begin
      if (push[k]) mem[k][wr_ptr[k][AW-1:0]] <= din[k];
    end
  end

  // FIFO pointers; ERR empties both lanes
  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      for (int k = 0; k < 2; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
      end
    end else if (state_q == ST_ERR) begin
      for (int k = 0; k < 2; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (push[k]) wr_ptr[k] <= wr_ptr[k] + PW'(1);
        if (pop[k])  rd_ptr[k] <= rd_ptr[k] + PW'(1);
      end
    end
  end

  // Alignment FSM next-state and registered-output next values
  always_comb begin
    state_d    = state_q;
    lane_sel_d = lane_sel_q;
    valid_d    = 1'b0;
    data_d     = FILL_EN ? IDLE_BYTE : data_q;
    stall_d    = stall_q;
    case (state_q)
      ST_IDLE: begin
        lane_sel_d = 1'b0;
        stall_d    = '0;
        if (!empty[0] && !empty[1]) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!empty[lane_sel_q]) begin
          valid_d    = 1'b1;
          data_d     = pop_data;
          lane_sel_d = ~lane_sel_q;
          stall_d    = '0;
        end else if (!lane_sel_q && empty[0] && empty[1]) begin
          state_d = ST_IDLE;
          stall_d = '0;
        end else begin
          stall_d = stall_q + SW'(1);
          if (stall_q == SW'(MAX_STALL - 1)) state_d = ST_ERR;
        end
      end
      ST_ERR: begin
        lane_sel_d = 1'b0;
        stall_d    = '0;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d    = ST_IDLE;
        lane_sel_d = 1'b0;
        stall_d    = '0;
      end
    endcase
  end

  assign skew_set = (state_q == ST_RUN) && (state_d == ST_ERR);

  // FSM state and output registers
  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      state_q    <= ST_IDLE;
      lane_sel_q <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= DATA_RST;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      lane_sel_q <= lane_sel_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      stall_q    <= stall_d;
    end
  end

  // Sticky flags; a set event in the same cycle beats err_clr
  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      skew_err <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (skew_set)     skew_err <= 1'b1;
      else if (err_clr) skew_err <= 1'b0;
      if (|drop)        overflow <= 1'b1;
      else if (err_clr) overflow <= 1'b0;
    end
  end

  assign state       = state_q;
  assign lane_sel    = lane_sel_q;
  assign valid_demux = valid_q;
  assign data_demux  = data_q;

endmodule

// File: tb/tb_unstripe_lane_scheduler.sv
// Directed bench for unstripe_lane_scheduler: a vector table for the basic
// interleave plus hand-written sequences for skew, overflow, flag clear,
// mid-stream reset and the idle-fill option (UNSTRIPE_IDLE_FILL_EN).
`timescale 1ns/1ps
module tb_unstripe_lane_scheduler;

  logic       clk_2f = 1'b0;
  logic       reset_L;
  logic       stripe_stb;
  logic [7:0] data_stripe_0, data_stripe_1;
  logic       valid_stripe_0, valid_stripe_1;
  logic       err_clr;
  logic [7:0] data_demux;
  logic       valid_demux;
  logic       lane_sel;
  logic [1:0] state;
  logic       skew_err;
  logic       overflow;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef UNSTRIPE_IDLE_FILL_EN
  localparam bit FILL = 1'b1;
`else
  localparam bit FILL = 1'b0;
`endif

  unstripe_lane_scheduler dut (
    .clk_2f        (clk_2f),
    .reset_L       (reset_L),
    .stripe_stb    (stripe_stb),
    .data_stripe_0 (data_stripe_0),
    .valid_stripe_0(valid_stripe_0),
    .data_stripe_1 (data_stripe_1),
    .valid_stripe_1(valid_stripe_1),
    .err_clr       (err_clr),
    .data_demux    (data_demux),
    .valid_demux   (valid_demux),
    .lane_sel      (lane_sel),
    .state         (state),
    .skew_err      (skew_err),
    .overflow      (overflow)
  );

  always #5 clk_2f = ~clk_2f;

  typedef struct {
    logic       stb;
    logic [7:0] d0;
    logic       v0;
    logic [7:0] d1;
    logic       v1;
    logic [1:0] st;
    logic       vo;
    logic       ls;
    logic [7:0] dout;
  } vec_t;

  vec_t tv[10];
  logic [7:0] got[$];
  logic [7:0] exp_q[8];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] st, input logic v,
                           input logic ls, input logic [7:0] d);
    logic [7:0] de;
    de = (FILL && !v) ? 8'hBC : d;
    chk({tag, ".state"},    {6'd0, state},       {6'd0, st});
    chk({tag, ".valid"},    {7'd0, valid_demux}, {7'd0, v});
    chk({tag, ".lane_sel"}, {7'd0, lane_sel},    {7'd0, ls});
    chk({tag, ".data"},     data_demux,          de);
  endtask

  task automatic drive(input logic stb, input logic [7:0] d0, input logic v0,
                       input logic [7:0] d1, input logic v1, input logic clr);
    stripe_stb     = stb;
    data_stripe_0  = d0;
    valid_stripe_0 = v0;
    data_stripe_1  = d1;
    valid_stripe_1 = v1;
    err_clr        = clr;
  endtask

  task automatic idle_in();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk_2f);
    #1;
  endtask

  task automatic tick_collect();
    tick();
    if (valid_demux) got.push_back(data_demux);
  endtask

  task automatic do_reset();
    idle_in();
    reset_L = 1'b0;
    repeat (2) @(posedge clk_2f);
    #1;
    reset_L = 1'b1;
  endtask

  initial begin
    // Basic interleave: lane 0 = 01,03,05, lane 1 = 02,04,06, strobe every other cycle
    tv[0] = '{1'b1, 8'h01, 1'b1, 8'h02, 1'b1, 2'd0, 1'b0, 1'b0, 8'h00};
    tv[1] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 2'd1, 1'b0, 1'b0, 8'h00};
    tv[2] = '{1'b1, 8'h03, 1'b1, 8'h04, 1'b1, 2'd1, 1'b1, 1'b1, 8'h01};
    tv[3] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 2'd1, 1'b1, 1'b0, 8'h02};
    tv[4] = '{1'b1, 8'h05, 1'b1, 8'h06, 1'b1, 2'd1, 1'b1, 1'b1, 8'h03};
    tv[5] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 2'd1, 1'b1, 1'b0, 8'h04};
    tv[6] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 2'd1, 1'b1, 1'b1, 8'h05};
    tv[7] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 2'd1, 1'b1, 1'b0, 8'h06};
    tv[8] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 8'h06};
    tv[9] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 8'h06};

    // ---- reset state ----
    idle_in();
    reset_L = 1'b0;
    #3;
    check_all("reset", 2'd0, 1'b0, 1'b0, 8'h00);
    chk("reset.skew_err", {7'd0, skew_err}, 8'h00);
    chk("reset.overflow", {7'd0, overflow}, 8'h00);
    do_reset();

    // ---- 1: basic interleave ----
    for (int i = 0; i < 10; i++) begin
      drive(tv[i].stb, tv[i].d0, tv[i].v0, tv[i].d1, tv[i].v1, 1'b0);
      tick();
      check_all($sformatf("interleave[%0d]", i), tv[i].st, tv[i].vo, tv[i].ls, tv[i].dout);
    end
    chk("interleave.overflow", {7'd0, overflow}, 8'h00);
    chk("interleave.skew_err", {7'd0, skew_err}, 8'h00);

    // ---- 2: skew ----
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'hA1 + 8'(i), 1'b1, 8'h00, 1'b0, 1'b0);
      tick();
      chk($sformatf("skew.wait_state[%0d]", i), {6'd0, state}, 8'h00);
      idle_in();
      tick();
    end
    drive(1'b1, 8'h00, 1'b0, 8'hB1, 1'b1, 1'b0);
    tick();
    chk("skew.e0_state", {6'd0, state}, 8'h00);
    idle_in();
    tick(); check_all("skew.e1", 2'd1, 1'b0, 1'b0, 8'h00);
    tick(); check_all("skew.e2", 2'd1, 1'b1, 1'b1, 8'hA1);
    tick(); check_all("skew.e3", 2'd1, 1'b1, 1'b0, 8'hB1);
    tick(); check_all("skew.e4", 2'd1, 1'b1, 1'b1, 8'hA2);
    tick(); check_all("skew.e5", 2'd1, 1'b0, 1'b1, 8'hA2);
    tick(); check_all("skew.e6", 2'd1, 1'b0, 1'b1, 8'hA2);
    chk("skew.e6_skew_err", {7'd0, skew_err}, 8'h00);
    tick(); check_all("skew.e7", 2'd2, 1'b0, 1'b1, 8'hA2);
    chk("skew.e7_skew_err", {7'd0, skew_err}, 8'h01);
    // pushes on both lanes during the ERR cycle must be discarded
    drive(1'b1, 8'hE0, 1'b1, 8'hE1, 1'b1, 1'b0);
    tick(); check_all("skew.e8", 2'd0, 1'b0, 1'b0, 8'hA2);
    chk("skew.e8_skew_err", {7'd0, skew_err}, 8'h01);
    chk("skew.e8_overflow", {7'd0, overflow}, 8'h00);
    idle_in();
    tick();
    chk("skew.err_push_discarded", {6'd0, state}, 8'h00);
    drive(1'b1, 8'h00, 1'b0, 8'hC1, 1'b1, 1'b0);
    tick();
    idle_in();
    tick();
    chk("skew.fifo0_flushed", {6'd0, state}, 8'h00);
    tick();
    chk("skew.fifo0_flushed2", {6'd0, state}, 8'h00);

    // ---- 3: overflow ----
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 8'h11 + 8'(i), 1'b1, 8'h00, 1'b0, 1'b0);
      tick();
      chk($sformatf("ovf.flag[%0d]", i), {7'd0, overflow}, (i >= 4) ? 8'h01 : 8'h00);
      idle_in();
      tick();
    end
    got.delete();
    exp_q = '{8'h11, 8'h21, 8'h12, 8'h22, 8'h13, 8'h23, 8'h14, 8'h24};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'h00, 1'b0, 8'h21 + 8'(i), 1'b1, 1'b0);
      tick_collect();
    end
    idle_in();
    for (int i = 0; i < 12; i++) tick_collect();
    chk("ovf.out_count", 8'(got.size()), 8'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ovf.out[%0d]", i), (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
    end
    chk("ovf.end_state", {6'd0, state}, 8'h00);

    // ---- 4: flag clear ----
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'h31 + 8'(i), 1'b1, 8'h00, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 8'h00, 1'b0, 8'h41, 1'b1, 1'b0);
    tick();
    idle_in();
    repeat (8) tick();
    chk("clr.pre_skew_err", {7'd0, skew_err}, 8'h01);
    chk("clr.pre_overflow", {7'd0, overflow}, 8'h01);
    chk("clr.pre_state", {6'd0, state}, 8'h00);
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    idle_in();
    chk("clr.skew_err", {7'd0, skew_err}, 8'h00);
    chk("clr.overflow", {7'd0, overflow}, 8'h00);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'h51 + 8'(i), 1'b1, 8'h00, 1'b0, 1'b0);
      tick();
    end
    chk("clr.refill_overflow", {7'd0, overflow}, 8'h00);
    drive(1'b1, 8'h55, 1'b1, 8'h00, 1'b0, 1'b1);
    tick();
    chk("clr.set_wins", {7'd0, overflow}, 8'h01);
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    idle_in();
    chk("clr.second_clear", {7'd0, overflow}, 8'h00);

    // ---- 5: reset mid-stream ----
    do_reset();
    drive(1'b1, 8'h61, 1'b1, 8'h71, 1'b1, 1'b0); tick();
    drive(1'b1, 8'h62, 1'b1, 8'h72, 1'b1, 1'b0); tick();
    drive(1'b1, 8'h63, 1'b1, 8'h73, 1'b1, 1'b0); tick();
    check_all("rst.e2", 2'd1, 1'b1, 1'b1, 8'h61);
    idle_in();
    tick(); check_all("rst.e3", 2'd1, 1'b1, 1'b0, 8'h71);
    tick(); check_all("rst.e4", 2'd1, 1'b1, 1'b1, 8'h62);
    #2;
    reset_L = 1'b0;
    #1;
    check_all("rst.async", 2'd0, 1'b0, 1'b0, 8'h00);
    @(posedge clk_2f);
    #1;
    reset_L = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_all($sformatf("rst.after[%0d]", i), 2'd0, 1'b0, 1'b0, 8'h00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
